// File: rtl/pad_check_pkg.sv
// Shared types and helpers for the pad counter checker.
package pad_check_pkg;

    // Checker sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    // Widest counter the saturating helper handles
    localparam int SAT_W = 32;

    // Increment a w-bit counter (w <= SAT_W), sticking at all-ones
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input int unsigned w);
        logic [SAT_W-1:0] max_val;
        max_val = SAT_W'(((SAT_W + 1)'(1) << w) - (SAT_W + 1)'(1));
        return (value >= max_val) ? max_val : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/pad_count_checker_if.sv
// Control, pad input and status bundle of the pad counter checker.
interface pad_count_checker_if #(
    parameter int WIDTH = 42,
    parameter int CNT_W = 16
);
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] pins_in;
    logic             locked;
    logic             error_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] good_count;
    logic [WIDTH-1:0] last_value;

    modport master (
        output enable, clear, pins_in,
        input  locked, error_pulse, err_count, good_count, last_value
    );

    modport slave (
        input  enable, clear, pins_in,
        output locked, error_pulse, err_count, good_count, last_value
    );
endinterface

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the asynchronous pad bus.
module pad_sync #(
    parameter int WIDTH = 42
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // Double-register each pad bit into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pad_count_checker.sv
// Receive-side checker for a free-running pad counter: synchronizes and
// stability-filters the pad bus, locks onto the sequence and counts
// correct (+1, wrapping) and incorrect steps.
//
// state   | meaning
// IDLE    | checking disabled, filter still running, no accepts
// ACQUIRE | waiting for the first accepted value to seed last_value
// TRACK   | every accepted value is checked against last_value + 1
module pad_count_checker
    import pad_check_pkg::*;
#(
    parameter int WIDTH         = 42,
    parameter int STABLE_CYCLES = 2,
    parameter int LOSS_ERRORS   = 4,
    parameter int CNT_W         = 16
) (
    input logic                clk,
    input logic                rst_n,
    pad_count_checker_if.slave bus
);
    localparam int RUN_W  = $clog2(STABLE_CYCLES + 2);
    localparam int MISS_W = $clog2(LOSS_ERRORS + 1);

    logic [WIDTH-1:0]  s;
    logic [WIDTH-1:0]  s_prev;
    logic [WIDTH-1:0]  last_value;
    logic [RUN_W-1:0]  run_q;
    logic [RUN_W-1:0]  run_cur;
    logic [MISS_W-1:0] miss_run;
    logic [CNT_W-1:0]  good_count;
    logic [CNT_W-1:0]  err_count;
    state_t            state;
    logic              locked;
    logic              error_pulse;
    logic              accept;
    logic              take;
    logic              is_match;
    logic              good_hit;
    logic              bad_hit;
    logic              loss;

    pad_sync #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pins_in),
        .q     (s)
    );

    // run_cur = cycles the synced value has held, including this one
    assign run_cur  = (s != s_prev) ? RUN_W'(1) : run_q;
    assign accept   = (int'(run_cur) == STABLE_CYCLES) && bus.enable;
    assign take     = accept && !bus.clear;
    assign is_match = (s == last_value + WIDTH'(1));
    assign good_hit = take && (state == TRACK) && is_match;
    assign bad_hit  = take && (state == TRACK) && !is_match;
    assign loss     = bad_hit && (int'(miss_run) + 1 >= LOSS_ERRORS);

    // Stability filter: run length saturates one past the accept point so
    // a held value is accepted only once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev <= '0;
            run_q  <= '0;
        end else begin
            s_prev <= s;
            run_q  <= (int'(run_cur) > STABLE_CYCLES) ? run_cur : run_cur + RUN_W'(1);
        end
    end

    // Sequencing FSM with registered locked / error_pulse and the miss run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            locked      <= 1'b0;
            error_pulse <= 1'b0;
            miss_run    <= '0;
        end else begin
            error_pulse <= bad_hit;
            if (bus.clear) begin
                state    <= bus.enable ? ACQUIRE : IDLE;
                locked   <= 1'b0;
                miss_run <= '0;
            end else if (!bus.enable) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                    end
                    ACQUIRE: begin
                        if (take) begin
                            state    <= TRACK;
                            locked   <= 1'b1;
                            miss_run <= '0;
                        end
                    end
                    TRACK: begin
                        if (good_hit) begin
                            miss_run <= '0;
                        end else if (loss) begin
                            state    <= ACQUIRE;
                            locked   <= 1'b0;
                            miss_run <= '0;
                        end else if (bad_hit) begin
                            miss_run <= miss_run + MISS_W'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating good / error counters; clear wins over any accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_count <= '0;
            err_count  <= '0;
        end else if (bus.clear) begin
            good_count <= '0;
            err_count  <= '0;
        end else if (good_hit) begin
            good_count <= CNT_W'(sat_inc(SAT_W'(good_count), CNT_W));
        end else if (bad_hit) begin
            err_count <= CNT_W'(sat_inc(SAT_W'(err_count), CNT_W));
        end
    end

    // Capture every accepted value, matching or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_value <= '0;
        end else if (take && (state == ACQUIRE || state == TRACK)) begin
            last_value <= s;
        end
    end

    assign bus.locked      = locked;
    assign bus.error_pulse = error_pulse;
    assign bus.good_count  = good_count;
    assign bus.err_count   = err_count;
    assign bus.last_value  = last_value;
endmodule

// File: tb/tb_pad_count_checker.sv
// Self-checking bench for pad_count_checker: per-cycle comparison against a
// behavioural model plus directed literal checks and randomized traffic.
module tb_pad_count_checker;
    localparam int W      = 42;
    localparam int STABLE = 2;
    localparam int LOSS   = 4;
    localparam int CW     = 6;
    localparam int CMAX   = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pad_count_checker_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    pad_count_checker #(
        .WIDTH(W), .STABLE_CYCLES(STABLE), .LOSS_ERRORS(LOSS), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulses_seen = 0;

    // Behavioural model: synced value is the pin value two edges ago;
    // hist holds synced values seen since reset (most recent last)
    logic [W-1:0] m_sync1, m_s, m_last;
    logic [W-1:0] hist[$];
    int           m_mode;    // 0 idle, 1 acquiring, 2 tracking
    int           m_good, m_err, m_miss;
    bit           m_pulse;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_sync1 = '0; m_s = '0; m_last = '0;
        hist.delete();
        m_mode = 0; m_good = 0; m_err = 0; m_miss = 0; m_pulse = 0;
    endtask

    // A value is accepted once it has been seen for exactly STABLE cycles
    function automatic bit m_accept();
        int n;
        n = hist.size();
        if (!bus.enable || n < STABLE) return 0;
        for (int i = 0; i < STABLE; i++)
            if (hist[n-1-i] != m_s) return 0;
        if (n > STABLE && hist[n-1-STABLE] == m_s) return 0;
        return 1;
    endfunction

    task automatic model_edge();
        bit acc;
        logic [W-1:0] nxt;
        acc = m_accept();
        nxt = m_last + 1'b1;
        m_pulse = 0;
        if (bus.clear) begin
            m_good = 0; m_err = 0; m_miss = 0;
            m_mode = bus.enable ? 1 : 0;
        end else if (!bus.enable) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (acc) begin
            if (m_mode == 1) begin
                m_mode = 2; m_miss = 0;
            end else if (m_s == nxt) begin
                if (m_good < CMAX) m_good++;
                m_miss = 0;
            end else begin
                if (m_err < CMAX) m_err++;
                m_pulse = 1;
                m_miss++;
                if (m_miss >= LOSS) begin m_mode = 1; m_miss = 0; end
            end
            m_last = m_s;
        end
        m_s = m_sync1;
        m_sync1 = bus.pins_in;
        hist.push_back(m_s);
        if (hist.size() > STABLE + 1) void'(hist.pop_front());
    endtask

    // One clock: advance the model, then compare every output mid-cycle
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("locked",      64'(bus.locked),      64'(m_mode == 2));
        chk("error_pulse", 64'(bus.error_pulse), 64'(m_pulse));
        chk("err_count",   64'(bus.err_count),   64'(m_err));
        chk("good_count",  64'(bus.good_count),  64'(m_good));
        chk("last_value",  64'(bus.last_value),  64'(m_last));
        if (bus.error_pulse) pulses_seen++;
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        bus.pins_in = v;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_locked", 64'(bus.locked),      64'd0);
        chk("rst_pulse",  64'(bus.error_pulse), 64'd0);
        chk("rst_err",    64'(bus.err_count),   64'd0);
        chk("rst_good",   64'(bus.good_count),  64'd0);
        chk("rst_last",   64'(bus.last_value),  64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int r;
        int r2;
        logic [W-1:0] drv;
        logic [W-1:0] ones;

        ones = '1;
        rst_n = 1'b1;
        bus.enable = 1'b0;
        bus.clear = 1'b0;
        bus.pins_in = '0;
        #2;
        do_reset();

        // Incrementing sequence 0..20
        bus.enable = 1'b1;
        for (int v = 0; v <= 20; v++) hold(W'(v), 4);
        chk("t1_good", 64'(bus.good_count), 64'd20);
        chk("t1_err", 64'(bus.err_count), 64'd0);
        chk("t1_locked", 64'(bus.locked), 64'd1);

        // Single skip: one error, then resumes from the new value
        p0 = pulses_seen;
        hold(W'(24), 4);
        chk("t3_pulses", 64'(pulses_seen - p0), 64'd1);
        chk("t3_err", 64'(bus.err_count), 64'd1);
        chk("t3_last", 64'(bus.last_value), 64'd24);
        hold(W'(25), 4);
        chk("t3_good", 64'(bus.good_count), 64'd21);
        chk("t3_locked", 64'(bus.locked), 64'd1);

        // Wrap through all-ones -> 0
        hold(ones - W'(1), 4);
        p0 = pulses_seen;
        hold(ones, 4);
        hold(W'(0), 4);
        hold(W'(1), 4);
        chk("t2_good", 64'(bus.good_count), 64'd24);
        chk("t2_pulses", 64'(pulses_seen - p0), 64'd0);

        // Four consecutive misses drop lock; relock on the next values
        hold(W'(3), 4);
        hold(W'(40), 4);
        hold(W'(7), 4);
        chk("t4_locked_after3", 64'(bus.locked), 64'd1);
        hold(W'(99), 4);
        chk("t4_err", 64'(bus.err_count), 64'd6);
        chk("t4_locked_after4", 64'(bus.locked), 64'd0);
        hold(W'(100), 4);
        chk("t4_relock", 64'(bus.locked), 64'd1);
        hold(W'(101), 4);
        chk("t4_good", 64'(bus.good_count), 64'd25);

        // Pins toggling every cycle never get accepted
        for (int i = 0; i < 20; i++) hold((i % 2) ? W'('h2AA) : W'('h155), 1);
        chk("t5_good", 64'(bus.good_count), 64'd25);
        chk("t5_err", 64'(bus.err_count), 64'd6);
        chk("t5_last", 64'(bus.last_value), 64'd101);
        hold(W'(102), 4);

        // clear in the accept cycle discards the accept
        hold(W'(103), 3);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("t6_good", 64'(bus.good_count), 64'd0);
        chk("t6_locked", 64'(bus.locked), 64'd0);
        chk("t6_last", 64'(bus.last_value), 64'd102);
        tick();
        hold(W'(104), 4);
        hold(W'(105), 4);
        chk("t6_relock_good", 64'(bus.good_count), 64'd1);
        chk("t6_relock_locked", 64'(bus.locked), 64'd1);

        // Asynchronous reset in TRACK
        do_reset();

        // Good counter saturation
        for (int i = 0; i <= 70; i++) hold(W'(500 + i), 3);
        chk("sat_model", 64'(m_good), 64'(CMAX));
        chk("sat_good", 64'(bus.good_count), 64'(CMAX));

        // Randomized traffic
        drv = W'(570);
        for (int it = 0; it < 500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      drv = drv + W'(1);
            else if (r < 75) drv = W'({$urandom(), $urandom()});
            else if (r < 88) drv = ones - W'($urandom_range(0, 2));
            else if (r < 94) drv = W'($urandom_range(0, 255));
            bus.pins_in = drv;
            r2 = $urandom_range(0, 99);
            if (r2 < 5) begin
                bus.enable = 1'b0;
                repeat ($urandom_range(1, 5)) tick();
                bus.enable = 1'b1;
            end else if (r2 < 8) begin
                bus.clear = 1'b1;
                tick();
                bus.clear = 1'b0;
            end
            repeat ($urandom_range(1, 6)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
